// File: rtl/axis_hit_pkg.sv
// axis_hit_pkg: shared widths, state encoding and beat packing for the hit unpacker
package axis_hit_pkg;
  localparam int HIT_WIDTH = 66;
  localparam int TAG_WIDTH = 62;
  localparam int CHAN_WIDTH = 7;
  localparam int BEAT_WIDTH = 72;
  localparam logic [CHAN_WIDTH-1:0] EMPTY_CHAN = 7'h7F;
  typedef enum logic {IDLE, SCAN} state_t;
  function automatic logic [BEAT_WIDTH-1:0] pack_beat(input logic [CHAN_WIDTH-1:0] chan,
                                                      input logic [TAG_WIDTH-1:0] tag);
    return {3'b000, chan, tag};
  endfunction
endpackage

// File: rtl/hit_prio_enc.sv
// hit_prio_enc: lowest-set-bit index of a hit mask, with any/single-bit flags
module hit_prio_enc
  import axis_hit_pkg::*;
(
  input  logic [HIT_WIDTH-1:0]  i_hits,
  output logic [CHAN_WIDTH-1:0] o_idx,
  output logic                  o_any,
  output logic                  o_single
);
  always_comb begin
    o_idx = '0;
    for (int i = HIT_WIDTH - 1; i >= 0; i--)
      if (i_hits[i]) o_idx = CHAN_WIDTH'(i);
    o_any = |i_hits;
    o_single = o_any && ((i_hits & (i_hits - 1'b1)) == '0);
  end
endmodule

// File: rtl/axis_hit_unpacker.sv
// axis_hit_unpacker: serialises a {tag, hit mask} window word into one AXI-S beat per hit.
// Optional AXIS_HIT_UNPACKER_EMPTY_EN: empty words emit a single ch=0x7F boundary beat.
module axis_hit_unpacker
  import axis_hit_pkg::*;
(
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [HIT_WIDTH-1:0]            cfg,
  input  logic [HIT_WIDTH+TAG_WIDTH-1:0]  s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [BEAT_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);
  state_t                  r_state, w_next_state;
  logic [HIT_WIDTH-1:0]    r_mask, w_mask;
  logic [TAG_WIDTH-1:0]    r_tag, w_tag;
  logic [BEAT_WIDTH-1:0]   r_tdata, w_tdata;
  logic                    r_tvalid, w_tvalid, r_tlast, w_tlast, r_s_tready;
  logic [HIT_WIDTH-1:0]    w_masked, w_rest, w_enc_in;
  logic [CHAN_WIDTH-1:0]   w_idx;
  logic                    w_any, w_single;
  logic [TAG_WIDTH-1:0]    w_in_tag;
  assign w_masked = s_axis_tdata[HIT_WIDTH-1:0] & cfg;
  assign w_in_tag = s_axis_tdata[HIT_WIDTH +: TAG_WIDTH];
  // r_mask keeps the bit of the beat on the bus; dropping it yields what follows
  assign w_rest = r_mask & (r_mask - 1'b1);
  assign w_enc_in = (r_state == IDLE) ? w_masked : w_rest;
  hit_prio_enc u_enc (
    .i_hits   (w_enc_in),
    .o_idx    (w_idx),
    .o_any    (w_any),
    .o_single (w_single)
  );
  always_comb begin
    w_next_state = r_state;
    w_mask = r_mask;
    w_tag = r_tag;
    w_tdata = r_tdata;
    w_tvalid = r_tvalid;
    w_tlast = r_tlast;
    if (r_state == IDLE) begin
      if (s_axis_tvalid && r_s_tready) begin
        w_mask = w_masked;
        w_tag = w_in_tag;
        if (w_any) begin
          w_next_state = SCAN;
          w_tvalid = 1'b1;
          w_tlast = w_single;
          w_tdata = pack_beat(w_idx, w_in_tag);
        end
`ifdef AXIS_HIT_UNPACKER_EMPTY_EN
        else begin
          w_next_state = SCAN;
          w_tvalid = 1'b1;
          w_tlast = 1'b1;
          w_tdata = pack_beat(EMPTY_CHAN, w_in_tag);
        end
`endif
      end
    end else if (r_tvalid && m_axis_tready) begin
      w_mask = w_rest;
      w_tvalid = w_any;
      w_tlast = w_single;
      w_tdata = w_any ? pack_beat(w_idx, r_tag) : r_tdata;
      w_next_state = w_any ? SCAN : IDLE;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_mask <= '0;
      r_tag <= '0;
      r_tdata <= '0;
      r_tvalid <= 1'b0;
      r_tlast <= 1'b0;
      r_s_tready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_mask <= w_mask;
      r_tag <= w_tag;
      r_tdata <= w_tdata;
      r_tvalid <= w_tvalid;
      r_tlast <= w_tlast;
      r_s_tready <= (w_next_state == IDLE);
    end
  end
  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast = r_tlast;
endmodule
